pipe_control: RTL and testbench

- Parametrised pipeline sequencing and hazard unit for the in-order core.
- Generates per-stage stall and per-boundary flush (bubble) controls for NUM_STAGES stages (index 0=F, 1=D, 2=E, 3=M, ..., NUM_STAGES-1=W).
- Two modes: serial (one instruction in flight, issued every NUM_STAGES cycles) and pipelined (load-use interlock, taken-branch squash, memory-busy freeze). Mode changes go through a drain sequence.
- Includes saturating stall and flush performance counters.

---
 rtl/pipe_control.sv | 177 +++++++++++++++++
 tb/tb_pipe_control.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// Pipeline sequencing and hazard control: per-stage stall and per-boundary
// flush generation for a NUM_STAGES in-order core. Supports a serial mode and a
// pipelined mode, with a drain sequence on the way back to serial. Includes
// saturating stall and flush performance counters.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_SERIAL | one instruction in flight, admitted only in slot 0
// ST_PIPE   | fully pipelined: memory freeze, branch squash, load-use interlock
// ST_DRAIN  | fetch held while in-flight work retires, then back to serial
module pipe_control #(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16,
    parameter int RESET_MODE = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  mode_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic                  id_rs1_vld_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs2_vld_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_is_load_i,
    input  logic                  br_taken_i,
    input  logic                  mem_busy_i,
    input  logic                  clr_cnt_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-2:0] flush_o,
    output logic                  mode_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam int                SLOT_W    = $clog2(NUM_STAGES);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_SERIAL = 2'd0,
        ST_PIPE   = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam state_t RESET_STATE = (RESET_MODE != 0) ? ST_PIPE : ST_SERIAL;

    state_t              r_state, w_state_nxt;
    logic [SLOT_W-1:0]   r_slot, w_slot_nxt;
    logic [NUM_STAGES-1:0] w_stall;
    logic [NUM_STAGES-2:0] w_flush;
    logic                w_load_use;
    logic [CNT_W-1:0]    r_stall_cnt, r_flush_cnt;

    // Register index 0 is hardwired, so a load targeting it never interlocks.
    assign w_load_use = ex_is_load_i && (ex_rd_i != '0) &&
                        ((id_rs1_vld_i && (id_rs1_i == ex_rd_i)) ||
                         (id_rs2_vld_i && (id_rs2_i == ex_rd_i)));

    // State and slot register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= RESET_STATE;
            r_slot  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    // Next state: a memory freeze holds everything, including a pending mode change.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        if (!mem_busy_i) begin
            case (r_state)
                ST_SERIAL: begin
                    if (mode_i) begin
                        w_state_nxt = ST_PIPE;
                        w_slot_nxt  = '0;
                    end else if (r_slot == SLOT_LAST) begin
                        w_slot_nxt = '0;
                    end else begin
                        w_slot_nxt = r_slot + SLOT_W'(1);
                    end
                end
                ST_PIPE: begin
                    if (!mode_i) begin
                        w_state_nxt = ST_DRAIN;
                        w_slot_nxt  = SLOT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_slot == SLOT_LAST) begin
                        w_state_nxt = ST_SERIAL;
                        w_slot_nxt  = '0;
                    end else begin
                        w_slot_nxt = r_slot + SLOT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = RESET_STATE;
                    w_slot_nxt  = '0;
                end
            endcase
        end
    end

    // Stall/flush decode; forced quiet while reset is held.
    always_comb begin
        w_stall = '0;
        w_flush = '0;
        if (rst_n_i) begin
            if (mem_busy_i) begin
                // Freeze F..M and bubble the M/W boundary (absent on a 4-stage core).
                for (int i = 0; i < NUM_STAGES; i++) begin
                    w_stall[i] = (i < 4);
                end
                for (int i = 0; i < NUM_STAGES - 1; i++) begin
                    w_flush[i] = (i == 3);
                end
            end else begin
                case (r_state)
                    ST_SERIAL: begin
                        if (r_slot != '0) begin
                            w_stall[0] = 1'b1;
                            w_flush[0] = 1'b1;
                        end
                    end
                    ST_PIPE: begin
                        if (br_taken_i) begin
                            w_flush[0] = 1'b1;
                            w_flush[1] = 1'b1;
                        end else if (w_load_use) begin
                            w_stall[0] = 1'b1;
                            w_stall[1] = 1'b1;
                            w_flush[1] = 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        w_stall[0] = 1'b1;
                        w_flush[0] = 1'b1;
                        w_flush[1] = br_taken_i;
                    end
                    default: begin
                        w_stall = '0;
                        w_flush = '0;
                    end
                endcase
            end
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clr_cnt_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall[0] && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if ((|w_flush) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_o     = w_stall;
    assign flush_o     = w_flush;
    assign mode_o      = (r_state == ST_PIPE);
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: stimulus pushes the expected per-cycle
// response, a negedge monitor pops and compares against the DUT outputs.
module tb_pipe_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, mode, rs1_vld, rs2_vld, is_load, br, mb, clr;
    logic [4:0] rs1, rs2, rd;

    logic [4:0]  stall, p_stall;
    logic [3:0]  flush, p_flush;
    logic        md, p_md;
    logic [3:0]  sc, fc;
    logic [15:0] p_sc, p_fc;

    pipe_control #(.NUM_STAGES(5), .REG_ADDR_W(5), .CNT_W(4), .RESET_MODE(0)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode),
        .id_rs1_i(rs1), .id_rs1_vld_i(rs1_vld), .id_rs2_i(rs2), .id_rs2_vld_i(rs2_vld),
        .ex_rd_i(rd), .ex_is_load_i(is_load), .br_taken_i(br), .mem_busy_i(mb),
        .clr_cnt_i(clr), .stall_o(stall), .flush_o(flush), .mode_o(md),
        .stall_cnt_o(sc), .flush_cnt_o(fc)
    );

    pipe_control #(.NUM_STAGES(5), .REG_ADDR_W(5), .CNT_W(16), .RESET_MODE(1)) dut_p (
        .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode),
        .id_rs1_i(rs1), .id_rs1_vld_i(rs1_vld), .id_rs2_i(rs2), .id_rs2_vld_i(rs2_vld),
        .ex_rd_i(rd), .ex_is_load_i(is_load), .br_taken_i(br), .mem_busy_i(mb),
        .clr_cnt_i(clr), .stall_o(p_stall), .flush_o(p_flush), .mode_o(p_md),
        .stall_cnt_o(p_sc), .flush_cnt_o(p_fc)
    );

    typedef struct {
        string      nm;
        logic [4:0] st;
        logic [3:0] fl;
        logic       md;
        bit         cc;
        logic [3:0] sc;
        logic [3:0] fc;
        bit         cp;
        logic       pmd;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic step(input string nm, input logic [4:0] st, input logic [3:0] fl,
                        input logic m, input bit cc, input logic [3:0] s_c,
                        input logic [3:0] f_c, input bit cp, input logic pm);
        exp_t e;
        e.nm = nm; e.st = st; e.fl = fl; e.md = m;
        e.cc = cc; e.sc = s_c; e.fc = f_c; e.cp = cp; e.pmd = pm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step_o(input string nm, input logic [4:0] st, input logic [3:0] fl,
                          input logic m);
        step(nm, st, fl, m, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic step_c(input string nm, input logic [4:0] st, input logic [3:0] fl,
                          input logic m, input logic [3:0] s_c, input logic [3:0] f_c);
        step(nm, st, fl, m, 1'b1, s_c, f_c, 1'b0, 1'b0);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tot++;
            if (stall !== e.st || flush !== e.fl || md !== e.md) begin
                $display("FAIL %s: stall=%b flush=%b mode=%b, required stall=%b flush=%b mode=%b",
                         e.nm, stall, flush, md, e.st, e.fl, e.md);
            end else begin
                n_pass++;
            end
            if (e.cc) begin
                n_tot++;
                if (sc !== e.sc || fc !== e.fc) begin
                    $display("FAIL %s_cnt: stall_cnt=%0d flush_cnt=%0d, required %0d %0d",
                             e.nm, sc, fc, e.sc, e.fc);
                end else begin
                    n_pass++;
                end
            end
            if (e.cp) begin
                n_tot++;
                if (p_md !== e.pmd) begin
                    $display("FAIL %s_pmode: mode=%b, required %b", e.nm, p_md, e.pmd);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n = 1'b0; mode = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        rs1_vld = 1'b0; rs2_vld = 1'b0; is_load = 1'b0; br = 1'b0; mb = 1'b1; clr = 1'b0;
        br = 1'b1;
        @(posedge clk); #1;
        step("in_reset", 5'b00000, 4'b0000, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1);

        // Release: cycle 0 is serial slot 0.
        rst_n = 1'b1; mb = 1'b0; br = 1'b0;
        step("ser_c0", 5'b00000, 4'b0000, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) step_o("ser_c1_4", 5'b00001, 4'b0001, 1'b0);
        step_c("ser_c5", 5'b00000, 4'b0000, 1'b0, 4'd4, 4'd4);
        step_o("ser_c6", 5'b00001, 4'b0001, 1'b0);
        mode = 1'b1;
        step_c("ser_c7", 5'b00001, 4'b0001, 1'b0, 4'd5, 4'd5);

        // Pipelined hazards.
        is_load = 1'b1; rd = 5'd7; rs2 = 5'd7; rs2_vld = 1'b1;
        step_o("load_use_rs2", 5'b00011, 4'b0010, 1'b1);
        rd = 5'd0;
        step_o("load_use_r0", 5'b00000, 4'b0000, 1'b1);
        rd = 5'd7; br = 1'b1;
        step_o("br_over_lu", 5'b00000, 4'b0011, 1'b1);
        br = 1'b0; is_load = 1'b0;
        step_o("pipe_idle", 5'b00000, 4'b0000, 1'b1);
        mb = 1'b1; br = 1'b1;
        for (int k = 0; k < 3; k++) step_o("mem_freeze", 5'b01111, 4'b1000, 1'b1);
        mb = 1'b0;
        step_o("br_after_mem", 5'b00000, 4'b0011, 1'b1);
        br = 1'b0; is_load = 1'b1; rd = 5'd3; rs1 = 5'd3; rs1_vld = 1'b1; rs2_vld = 1'b0;
        step_o("load_use_rs1", 5'b00011, 4'b0010, 1'b1);
        rs1_vld = 1'b0;
        step_o("lu_rs1_invalid", 5'b00000, 4'b0000, 1'b1);
        is_load = 1'b0;

        // Drain with a branch, a mid-drain freeze and mode_i raised early.
        mode = 1'b0;
        step_o("pipe_to_drain", 5'b00000, 4'b0000, 1'b1);
        mode = 1'b1; br = 1'b1;
        step_o("drain1_br", 5'b00001, 4'b0011, 1'b0);
        br = 1'b0; mb = 1'b1;
        step_o("drain_freeze", 5'b01111, 4'b1000, 1'b0);
        mb = 1'b0;
        step_o("drain2", 5'b00001, 4'b0001, 1'b0);
        step_o("drain3", 5'b00001, 4'b0001, 1'b0);
        step_o("drain4", 5'b00001, 4'b0001, 1'b0);
        step_o("serial_after_drain", 5'b00000, 4'b0000, 1'b0);
        mode = 1'b0;
        step_o("pipe_again", 5'b00000, 4'b0000, 1'b1);
        step_o("drain_b1", 5'b00001, 4'b0001, 1'b0);
        step_o("drain_b2", 5'b00001, 4'b0001, 1'b0);

        // Reset mid-drain with a freeze request present.
        rst_n = 1'b0; mb = 1'b1; br = 1'b1;
        step("rst_mid_drain", 5'b00000, 4'b0000, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1);
        rst_n = 1'b1; mb = 1'b0; br = 1'b0;
        step("rel_c0", 5'b00000, 4'b0000, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1);

        // Long serial run: 32 stall cycles saturate the 4-bit counters.
        for (int k = 1; k <= 40; k++) begin
            if (k % 5 == 0) step_o("ser_run", 5'b00000, 4'b0000, 1'b0);
            else            step_o("ser_run", 5'b00001, 4'b0001, 1'b0);
        end
        clr = 1'b1;
        step_c("sat_clr", 5'b00001, 4'b0001, 1'b0, 4'd15, 4'd15);
        clr = 1'b0;
        step_c("after_clr", 5'b00001, 4'b0001, 1'b0, 4'd0, 4'd0);
        step_c("count_one", 5'b00001, 4'b0001, 1'b0, 4'd1, 4'd1);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_tot++;
            $display("FAIL drain_queue: %0d entries left, required 0", q.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
